cycle_tracer: RTL and testbench
===============================

# cycle_tracer

Post-pass reader for the Bellman relaxation engine's vertex memory. After relaxation completes, it performs one extra edge scan to find a vertex still improvable, which proves a negative (arbitrage) cycle exists. It then walks the predecessor chain into the cycle and streams the cycle's vertex IDs out on a valid/ready interface. It sits between the Bellman engine and the trade-order logic and owns only read access to vertmat/adjmat.

## Interface
- NODES, 16, vertex count; vertex IDs are 0..NODES-1
- PRED_W, 8, vertex ID / address width
- WEIGHT_W, 32, signed weight width; a vertmat word is {pred[PRED_W-1:0], weight[WEIGHT_W-1:0]}
- INF, 32'h777fffff, unreached-vertex weight sentinel
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; one clock
- start  in  1  one-cycle pulse; begin a trace (driven from bellman_done rising edge)
- vertmat_addr_a / vertmat_addr_b  out  PRED_W  read addresses
- vertmat_q_a / vertmat_q_b  in  PRED_W+WEIGHT_W  read data, valid one cycle after address
- adjmat_row_addr / adjmat_col_addr  out  PRED_W  edge (i,j) address
- adjmat_q  in  WEIGHT_W  signed edge weight, 0 = no edge; one-cycle read latency
- cyc_valid  out  1  cyc_vertex valid
- cyc_ready  in  1  consumer accepts beat
- cyc_vertex  out  PRED_W  cycle vertex ID
- cyc_last  out  1  final vertex of cycle
- busy  out  1  trace in progress
- done  out  1  held high from trace end until next start
- found  out  1  valid when done; 1 = negative cycle emitted
- err  out  1  valid when done; chain did not close within NODES beats

## Operation
- States: IDLE, SCAN_ADDR, SCAN_CHK, WALK_ADDR, WALK_STEP, EMIT, EMIT_RD, DONE.
- IDLE: start -> clear done/found/err, i=j=0, SCAN_ADDR. start in any non-IDLE/non-DONE state is ignored; start in DONE restarts.
- SCAN_ADDR: drive addr_a=i, addr_b=j, adj row=i, col=j -> SCAN_CHK.
- SCAN_CHK: svw=q_a weight, dvw=q_b weight, e=adjmat_q. Improvable iff e!=0 and svw!=INF and (svw+e) < dvw. Compare as signed WEIGHT_W+1 bits with sign extension; no wrap.
  - Improvable: seed=j, walk count n=0 -> WALK_ADDR.
  - Otherwise advance (i,j) in row-major order (j fastest). Last edge (NODES-1,NODES-1) -> DONE, found=0.
- WALK_ADDR: addr_a=seed -> WALK_STEP. WALK_STEP: seed=q_a pred, n++. When n reaches NODES, c=seed (now guaranteed on the cycle), cur=c, beat count m=0 -> EMIT; otherwise -> WALK_ADDR.
- EMIT: cyc_valid=1, cyc_vertex=cur, addr_a=cur. On cyc_valid&&cyc_ready -> EMIT_RD, m++.
- EMIT_RD: p=q_a pred. If p==c -> DONE, found=1. Else if m==NODES -> DONE, found=1, err=1. Else cur=p -> EMIT.
- cyc_last is combinational in EMIT: asserted when the already-read pred(cur)==c, or m==NODES-1. EMIT therefore keeps addr_a=cur, and the pred is available from cycle 2 of EMIT.
- Required change to the above: add a one-cycle EMIT_PRE state before each EMIT that drives addr_a=cur. pred(cur) is latched in EMIT_PRE+1. cyc_valid asserts only once pred is known. EMIT_RD is then unused; decide end-of-cycle directly on the handshake.
- Emission order is predecessor order (c, pred(c), …). The consumer reverses it for trade direction.
- No write ports; never drives vertmat write enables.

## Timing
- Reset (async): state=IDLE; all outputs 0, including addresses, cyc_*, busy, done, found, err.
- busy=1 from the cycle after start until DONE entry.
- Scan: 2 cycles/edge; worst case 2·NODES² cycles.
- Walk: 2·NODES cycles.
- Emit: ≥2 cycles/vertex (EMIT_PRE + EMIT); additional cycles while cyc_ready=0.
- While cyc_valid=1 and cyc_ready=0: cyc_vertex and cyc_last stable.
- Reset mid-trace aborts immediately; no partial cyc_last is owed.

## Structure
- Shared package holds NODES, PRED_W, WEIGHT_W, INF, the vertmat word typedef (pred/weight fields), and the state enum. The Bellman engine uses the same package.
- One sub-module: relax_check. Combinational improvable predicate (svw, dvw, e -> flag), shared with the Bellman engine's relaxation compare.

## Test plan
- NODES=4; all weights finite, no improvable edge -> done=1, found=0, no cyc_valid, done at ≈32 cycles after start.
- v0={0,0}, v1={3,-5}, v2={1,-3}, v3={2,-6}; edges (1,2)=2, (2,3)=-3, (3,1)=-2 -> seed 1, c=3; beats 3,2,1; cyc_last on 1; found=1, err=0.
- Same as previous with cyc_ready low 5 cycles on beat 2 -> cyc_vertex=2 held, no beat lost or duplicated.
- v2 weight=INF with edge (2,0)=-100 -> not improvable; found=0.
- pred(2)=2 self-loop, edge (2,2)=-1, v2 weight 0 -> single beat 2 with cyc_last; found=1.
- Assert reset during scan, then start again (scenario 2 data) -> outputs 0 during reset; identical beat sequence on restart.

Source files
------------

// File: rtl/cycle_tracer_pkg.sv
// rtl/cycle_tracer_pkg.sv - shared constants, vertmat word layout and tracer states
package cycle_tracer_pkg;

    localparam int NODES    = 16;
    localparam int PRED_W   = 8;
    localparam int WEIGHT_W = 32;

    // Weight the relaxation engine leaves on vertices it never reached
    localparam logic signed [WEIGHT_W-1:0] INF = 32'sh777fffff;

    typedef struct packed {
        logic [PRED_W-1:0]          pred;
        logic signed [WEIGHT_W-1:0] weight;
    } vert_word_t;

    typedef enum logic [2:0] {
        IDLE,
        SCAN_ADDR,
        SCAN_CHK,
        WALK_ADDR,
        WALK_STEP,
        EMIT_PRE,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/cycle_tracer_relax_check.sv
// rtl/cycle_tracer_relax_check.sv - edge relaxation predicate shared with the Bellman engine
module relax_check
    import cycle_tracer_pkg::*;
(
    input  logic signed [WEIGHT_W-1:0] svw,
    input  logic signed [WEIGHT_W-1:0] dvw,
    input  logic signed [WEIGHT_W-1:0] e,
    output logic                       improvable
);

    // One guard bit so svw+e can never wrap past the destination weight
    logic signed [WEIGHT_W:0] sum;
    logic signed [WEIGHT_W:0] dst;

    always_comb begin
        sum        = {svw[WEIGHT_W-1], svw} + {e[WEIGHT_W-1], e};
        dst        = {dvw[WEIGHT_W-1], dvw};
        improvable = (e != '0) && (svw != INF) && (sum < dst);
    end

endmodule

// File: rtl/cycle_tracer.sv
// rtl/cycle_tracer.sv - finds a still-improvable edge, walks into the negative cycle, streams its vertices
module cycle_tracer
    import cycle_tracer_pkg::*;
#(
    parameter int NUM_NODES = NODES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic [PRED_W-1:0]          vertmat_addr_a,
    output logic [PRED_W-1:0]          vertmat_addr_b,
    input  logic [PRED_W+WEIGHT_W-1:0] vertmat_q_a,
    input  logic [PRED_W+WEIGHT_W-1:0] vertmat_q_b,
    output logic [PRED_W-1:0]          adjmat_row_addr,
    output logic [PRED_W-1:0]          adjmat_col_addr,
    input  logic signed [WEIGHT_W-1:0] adjmat_q,
    output logic                       cyc_valid,
    input  logic                       cyc_ready,
    output logic [PRED_W-1:0]          cyc_vertex,
    output logic                       cyc_last,
    output logic                       busy,
    output logic                       done,
    output logic                       found,
    output logic                       err
);

    localparam logic [PRED_W-1:0] LAST_ID = PRED_W'(NUM_NODES - 1);
    localparam logic [PRED_W-1:0] ONE     = PRED_W'(1);

    state_t state, state_nxt;

    logic [PRED_W-1:0] i_q, i_nxt;
    logic [PRED_W-1:0] j_q, j_nxt;
    logic [PRED_W-1:0] seed_q, seed_nxt;
    logic [PRED_W-1:0] c_q, c_nxt;
    logic [PRED_W-1:0] cur_q, cur_nxt;
    logic [PRED_W-1:0] n_q, n_nxt;
    logic [PRED_W-1:0] m_q, m_nxt;
    logic              done_q, done_nxt;
    logic              found_q, found_nxt;
    logic              err_q, err_nxt;

    vert_word_t word_a;
    vert_word_t word_b;
    logic       improvable;
    logic       pred_is_c;
    logic [PRED_W-1:0] unused_pred_b;

    assign word_a        = vert_word_t'(vertmat_q_a);
    assign word_b        = vert_word_t'(vertmat_q_b);
    assign unused_pred_b = word_b.pred;
    assign pred_is_c     = (word_a.pred == c_q);

    relax_check u_relax_check (
        .svw        (word_a.weight),
        .dvw        (word_b.weight),
        .e          (adjmat_q),
        .improvable (improvable)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            seed_q  <= '0;
            c_q     <= '0;
            cur_q   <= '0;
            n_q     <= '0;
            m_q     <= '0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            i_q     <= i_nxt;
            j_q     <= j_nxt;
            seed_q  <= seed_nxt;
            c_q     <= c_nxt;
            cur_q   <= cur_nxt;
            n_q     <= n_nxt;
            m_q     <= m_nxt;
            done_q  <= done_nxt;
            found_q <= found_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        i_nxt           = i_q;
        j_nxt           = j_q;
        seed_nxt        = seed_q;
        c_nxt           = c_q;
        cur_nxt         = cur_q;
        n_nxt           = n_q;
        m_nxt           = m_q;
        done_nxt        = done_q;
        found_nxt       = found_q;
        err_nxt         = err_q;
        vertmat_addr_a  = '0;
        vertmat_addr_b  = '0;
        adjmat_row_addr = '0;
        adjmat_col_addr = '0;
        cyc_valid       = 1'b0;
        cyc_vertex      = '0;
        cyc_last        = 1'b0;
        busy            = (state != IDLE) && (state != DONE);

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    done_nxt  = 1'b0;
                    found_nxt = 1'b0;
                    err_nxt   = 1'b0;
                    i_nxt     = '0;
                    j_nxt     = '0;
                    state_nxt = SCAN_ADDR;
                end
            end

            SCAN_ADDR: begin
                vertmat_addr_a  = i_q;
                vertmat_addr_b  = j_q;
                adjmat_row_addr = i_q;
                adjmat_col_addr = j_q;
                state_nxt       = SCAN_CHK;
            end

            SCAN_CHK: begin
                if (improvable) begin
                    seed_nxt  = j_q;
                    n_nxt     = '0;
                    state_nxt = WALK_ADDR;
                end else if (j_q == LAST_ID) begin
                    if (i_q == LAST_ID) begin
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        i_nxt     = i_q + ONE;
                        j_nxt     = '0;
                        state_nxt = SCAN_ADDR;
                    end
                end else begin
                    j_nxt     = j_q + ONE;
                    state_nxt = SCAN_ADDR;
                end
            end

            WALK_ADDR: begin
                vertmat_addr_a = seed_q;
                state_nxt      = WALK_STEP;
            end

            // NODES predecessor hops from any reachable vertex must land on the cycle
            WALK_STEP: begin
                seed_nxt = word_a.pred;
                n_nxt    = n_q + ONE;
                if (n_q == LAST_ID) begin
                    c_nxt     = word_a.pred;
                    cur_nxt   = word_a.pred;
                    m_nxt     = '0;
                    state_nxt = EMIT_PRE;
                end else begin
                    state_nxt = WALK_ADDR;
                end
            end

            EMIT_PRE: begin
                vertmat_addr_a = cur_q;
                state_nxt      = EMIT;
            end

            // Address stays on cur so pred(cur), and hence cyc_last, holds through a stall
            EMIT: begin
                vertmat_addr_a = cur_q;
                cyc_valid      = 1'b1;
                cyc_vertex     = cur_q;
                cyc_last       = pred_is_c || (m_q == LAST_ID);
                if (cyc_ready) begin
                    m_nxt = m_q + ONE;
                    if (pred_is_c) begin
                        done_nxt  = 1'b1;
                        found_nxt = 1'b1;
                        state_nxt = DONE;
                    end else if (m_q == LAST_ID) begin
                        done_nxt  = 1'b1;
                        found_nxt = 1'b1;
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        cur_nxt   = word_a.pred;
                        state_nxt = EMIT_PRE;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign done  = done_q;
    assign found = found_q;
    assign err   = err_q;

endmodule

// File: tb/tb_cycle_tracer.sv
// tb/tb_cycle_tracer.sv - randomized and directed bench for cycle_tracer against a graph-level model
module tb_cycle_tracer;
    import cycle_tracer_pkg::*;

    localparam int N     = 4;
    localparam int INF_I = 32'h777fffff;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       start;
    logic [PRED_W-1:0]          vertmat_addr_a, vertmat_addr_b;
    logic [PRED_W+WEIGHT_W-1:0] vertmat_q_a, vertmat_q_b;
    logic [PRED_W-1:0]          adjmat_row_addr, adjmat_col_addr;
    logic signed [WEIGHT_W-1:0] adjmat_q;
    logic                       cyc_valid, cyc_ready, cyc_last;
    logic [PRED_W-1:0]          cyc_vertex;
    logic                       busy, done, found, err;

    int pred_m [N];
    int wt_m   [N];
    int adj    [N][N];

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;
    int stall_left = 0;

    always #5 clk = ~clk;

    cycle_tracer #(.NUM_NODES(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .vertmat_addr_a  (vertmat_addr_a),
        .vertmat_addr_b  (vertmat_addr_b),
        .vertmat_q_a     (vertmat_q_a),
        .vertmat_q_b     (vertmat_q_b),
        .adjmat_row_addr (adjmat_row_addr),
        .adjmat_col_addr (adjmat_col_addr),
        .adjmat_q        (adjmat_q),
        .cyc_valid       (cyc_valid),
        .cyc_ready       (cyc_ready),
        .cyc_vertex      (cyc_vertex),
        .cyc_last        (cyc_last),
        .busy            (busy),
        .done            (done),
        .found           (found),
        .err             (err)
    );

    function automatic logic [PRED_W+WEIGHT_W-1:0] rd_word(input logic [PRED_W-1:0] a);
        int ai;
        ai = int'(a);
        if (ai < N) return {PRED_W'(pred_m[ai]), wt_m[ai]};
        return '0;
    endfunction

    always @(posedge clk) begin
        vertmat_q_a <= rd_word(vertmat_addr_a);
        vertmat_q_b <= rd_word(vertmat_addr_b);
        if (int'(adjmat_row_addr) < N && int'(adjmat_col_addr) < N)
            adjmat_q <= adj[int'(adjmat_row_addr)][int'(adjmat_col_addr)];
        else
            adjmat_q <= '0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Graph-level reference: first improvable edge in row-major order, NODES hops, then follow preds
    task automatic model(output bit ef, output bit ee, output int eb[$]);
        int seed, v, c, cur;
        seed = -1;
        ef = 0;
        ee = 0;
        eb.delete();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (seed < 0 && adj[i][j] != 0 && wt_m[i] != INF_I &&
                    (longint'(wt_m[i]) + longint'(adj[i][j]) < longint'(wt_m[j])))
                    seed = j;
        if (seed < 0) return;
        ef = 1;
        v = seed;
        for (int k = 0; k < N; k++) v = pred_m[v];
        c = v;
        cur = c;
        forever begin
            eb.push_back(cur);
            if (pred_m[cur] == c) break;
            if (eb.size() == N) begin
                ee = 1;
                break;
            end
            cur = pred_m[cur];
        end
    endtask

    task automatic run_trace(input string tag, input int exp_cycles);
        bit ef, ee;
        int eb[$];
        int gv[$];
        int gl[$];
        int cyc;
        bit prev_stall;
        logic [PRED_W-1:0] pv;
        logic pl;
        model(ef, ee, eb);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "/busy_after_start"}, busy, 1);
        cyc = 0;
        prev_stall = 0;
        pv = '0;
        pl = 1'b0;
        while (!done && cyc < 3000) begin
            if (ready_mode == 2) begin
                if (cyc_valid && cyc_vertex == 2 && stall_left > 0) begin
                    cyc_ready = 1'b0;
                    stall_left--;
                end else begin
                    cyc_ready = 1'b1;
                end
            end else if (ready_mode == 1) begin
                cyc_ready = 1'($urandom_range(0, 1));
            end else begin
                cyc_ready = 1'b1;
            end
            if (prev_stall) begin
                chk({tag, "/hold_valid"}, cyc_valid, 1);
                chk({tag, "/hold_vertex"}, cyc_vertex, pv);
                chk({tag, "/hold_last"}, cyc_last, pl);
            end
            if (cyc_valid) begin
                if (cyc_ready) begin
                    gv.push_back(int'(cyc_vertex));
                    gl.push_back(int'(cyc_last));
                end
                prev_stall = !cyc_ready;
                pv = cyc_vertex;
                pl = cyc_last;
            end else begin
                prev_stall = 0;
            end
            @(negedge clk);
            cyc++;
        end
        cyc_ready = 1'b1;
        chk({tag, "/done"}, done, 1);
        if (exp_cycles > 0) chk({tag, "/done_cycles"}, cyc, exp_cycles);
        chk({tag, "/found"}, found, ef);
        chk({tag, "/err"}, err, ee);
        chk({tag, "/busy_end"}, busy, 0);
        chk({tag, "/nbeats"}, gv.size(), eb.size());
        for (int k = 0; k < gv.size() && k < eb.size(); k++) begin
            chk($sformatf("%s/vertex%0d", tag, k), gv[k], eb[k]);
            chk($sformatf("%s/last%0d", tag, k), gl[k], (k == eb.size() - 1) ? 1 : 0);
        end
    endtask

    task automatic clear_graph();
        for (int i = 0; i < N; i++) begin
            pred_m[i] = i;
            wt_m[i] = 0;
            for (int j = 0; j < N; j++) adj[i][j] = 0;
        end
    endtask

    task automatic load_arb();
        clear_graph();
        pred_m[0] = 0; wt_m[0] = 0;
        pred_m[1] = 3; wt_m[1] = -5;
        pred_m[2] = 1; wt_m[2] = -3;
        pred_m[3] = 2; wt_m[3] = -6;
        adj[1][2] = 2;
        adj[2][3] = -3;
        adj[3][1] = -2;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/busy"}, busy, 0);
        chk({tag, "/done"}, done, 0);
        chk({tag, "/found_err"}, {found, err}, 0);
        chk({tag, "/cyc"}, {cyc_valid, cyc_last, cyc_vertex}, 0);
        chk({tag, "/addr"}, {vertmat_addr_a, vertmat_addr_b, adjmat_row_addr, adjmat_col_addr}, 0);
    endtask

    function automatic int rand_w();
        case ($urandom_range(0, 7))
            0:       return INF_I;
            1:       return int'(32'h80000000 + $urandom_range(0, 3));
            default: return int'($urandom_range(0, 60)) - 30;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        cyc_ready = 1'b1;
        clear_graph();
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        wt_m[1] = 5; wt_m[2] = 8;
        adj[0][1] = 5; adj[1][2] = 3;
        run_trace("no_cycle", 2 * N * N);

        load_arb();
        ready_mode = 0;
        run_trace("arb", 0);

        ready_mode = 2;
        stall_left = 5;
        run_trace("arb_stall", 0);
        chk("arb_stall/stall_used", stall_left, 0);
        ready_mode = 0;

        clear_graph();
        wt_m[2] = INF_I;
        adj[2][0] = -100;
        run_trace("inf_src", 0);

        clear_graph();
        adj[2][2] = -1;
        run_trace("self_loop", 0);

        clear_graph();
        wt_m[0] = int'(32'h80000000);
        adj[0][1] = -1;
        run_trace("no_wrap", 0);

        load_arb();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        run_trace("arb_restart", 0);

        ready_mode = 1;
        for (int t = 0; t < 40; t++) begin
            clear_graph();
            for (int i = 0; i < N; i++) begin
                pred_m[i] = int'($urandom_range(0, N - 1));
                wt_m[i] = rand_w();
                for (int j = 0; j < N; j++)
                    if ($urandom_range(0, 9) < 4)
                        adj[i][j] = ($urandom_range(0, 7) == 0) ? int'(32'h80000001) : rand_w();
            end
            run_trace($sformatf("rand%0d", t), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
